// File: rtl/tensor_accel_pkg.sv
// Shared definitions for the tensor accelerator datapath blocks:
// default activation vector geometry, the feeder FSM state type and
// a small helper for the prefetch read-credit decision.
package tensor_accel_pkg;

  localparam int ACT_ARRAY_SIZE = 4;
  localparam int ACT_DATA_WIDTH = 8;
  localparam int ACT_VEC_W      = ACT_ARRAY_SIZE * ACT_DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } feeder_state_t;

  // A read may be issued only if every word already buffered or still
  // returning from the SRAM leaves room for one more. Pops happening in
  // the same cycle are deliberately not credited.
  function automatic logic read_credit_ok(input int fill, input int depth);
    return fill < depth;
  endfunction

endpackage

// File: rtl/act_prefetch_fifo.sv
// First-word-fall-through synchronous FIFO used to buffer SRAM read data
// ahead of the systolic array. When empty, a word being pushed is
// presented on the output in the same cycle, so a returning read can be
// consumed without first landing in storage. Overflow protection is the
// caller's job (the feeder's credit rule never pushes into a full FIFO).
module act_prefetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic                       valid_o,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             empty;
  logic             wr_en;
  logic             rd_en;

  // A push that is popped straight through while empty never touches storage.
  assign empty   = (count_q == '0);
  assign wr_en   = push_i && !(empty && pop_i);
  assign rd_en   = pop_i && !empty;
  assign valid_o = !empty || push_i;
  assign count_o = count_q;

  // Output head: stored word if any, else the bypassed push, else zero.
  always_comb begin
    data_o = '0;
    if (!empty) begin
      data_o = mem_q[rd_ptr_q];
    end else if (push_i) begin
      data_o = push_data_i;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; data only, no reset needed.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/act_stream_feeder.sv
// Activation stream feeder: walks cfg_rows*cfg_k_tiles consecutive SRAM
// words from cfg_base_addr and streams them to the systolic array over a
// valid/ready handshake. A small prefetch FIFO hides the one-cycle SRAM
// latency and absorbs backpressure.
// Optional build macro ACT_STREAM_FEEDER_PERF_EN adds stall/bubble cycle
// counters; without it the perf ports are tied to zero.
module act_stream_feeder
  import tensor_accel_pkg::*;
#(
  parameter int ARRAY_SIZE = ACT_ARRAY_SIZE,
  parameter int DATA_WIDTH = ACT_DATA_WIDTH,
  parameter int ADDR_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [ADDR_WIDTH-1:0]            cfg_base_addr,
  input  logic [15:0]                      cfg_rows,
  input  logic [15:0]                      cfg_k_tiles,
  output logic                             busy,
  output logic                             done,
  output logic                             mem_rd_en,
  output logic [ADDR_WIDTH-1:0]            mem_rd_addr,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] mem_rd_data,
  output logic                             act_valid,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] act_data,
  input  logic                             act_ready,
  output logic [31:0]                      perf_stall_cycles,
  output logic [31:0]                      perf_bubble_cycles
);

  localparam int VEC_W = ARRAY_SIZE * DATA_WIDTH;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  feeder_state_t         state_q, state_d;
  logic [31:0]           n_q;
  logic [31:0]           rd_cnt_q;
  logic [31:0]           pop_cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  rd_pend_q;

  logic [31:0]           n_start;
  logic                  start_ok;
  logic                  credit_ok;
  logic                  pop;
  logic                  last_pop;
  logic [CNT_W-1:0]      fifo_count;

  assign n_start   = 32'(cfg_rows) * 32'(cfg_k_tiles);
  assign start_ok  = (state_q == ST_IDLE) && start;
  assign credit_ok = read_credit_ok(int'(fifo_count) + int'(rd_pend_q), FIFO_DEPTH);
  assign pop       = act_valid && act_ready;
  // The final vector is only ever accepted after every read has returned,
  // so its handshake also implies nothing is in flight or buffered.
  assign last_pop  = pop && (pop_cnt_q == n_q - 32'd1);
  assign mem_rd_addr = addr_q;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state and control outputs.
  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    mem_rd_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = (n_start == 32'd0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        busy      = 1'b1;
        mem_rd_en = credit_ok;
        if (credit_ok && (rd_cnt_q == n_q - 32'd1)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (last_pop) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stream configuration, read address walk and progress counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_q       <= '0;
      rd_cnt_q  <= '0;
      pop_cnt_q <= '0;
      addr_q    <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      rd_pend_q <= mem_rd_en;
      if (start_ok) begin
        n_q       <= n_start;
        addr_q    <= cfg_base_addr;
        rd_cnt_q  <= '0;
        pop_cnt_q <= '0;
      end else begin
        if (mem_rd_en) begin
          addr_q   <= addr_q + 1'b1;
          rd_cnt_q <= rd_cnt_q + 32'd1;
        end
        if (pop) pop_cnt_q <= pop_cnt_q + 32'd1;
      end
    end
  end

  // Read data is pushed exactly one cycle after its request; a request
  // cancelled by reset leaves rd_pend_q low so its data is dropped.
  act_prefetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (VEC_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (rd_pend_q),
    .push_data_i (mem_rd_data),
    .pop_i       (pop),
    .valid_o     (act_valid),
    .data_o      (act_data),
    .count_o     (fifo_count)
  );

`ifdef ACT_STREAM_FEEDER_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] bubble_q;

  // Saturating stall/bubble counters, cleared when a stream is launched.
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (act_valid && !act_ready && (stall_q != '1)) stall_q <= stall_q + 32'd1;
      if (busy && !act_valid && (bubble_q != '1))     bubble_q <= bubble_q + 32'd1;
    end
  end

  assign perf_stall_cycles  = stall_q;
  assign perf_bubble_cycles = bubble_q;
`else
  assign perf_stall_cycles  = '0;
  assign perf_bubble_cycles = '0;
`endif

endmodule

// File: tb/tb_act_stream_feeder.sv
// Scoreboard bench for act_stream_feeder: stimulus pushes the expected
// read addresses and vectors of each stream into queues; a monitor pops
// and compares on every read request and every accepted vector.
`timescale 1ns/1ps
module tb_act_stream_feeder;
  import tensor_accel_pkg::*;

  localparam int DEPTH = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [15:0]          cfg_base_addr = '0;
  logic [15:0]          cfg_rows = '0;
  logic [15:0]          cfg_k_tiles = '0;
  logic                 busy, done, mem_rd_en;
  logic [15:0]          mem_rd_addr;
  logic [ACT_VEC_W-1:0] mem_rd_data = 32'hDEADBEEF;
  logic                 act_valid;
  logic [ACT_VEC_W-1:0] act_data;
  logic                 act_ready = 1'b1;
  logic [31:0]          perf_stall_cycles, perf_bubble_cycles;

  act_stream_feeder #(
    .ARRAY_SIZE (ACT_ARRAY_SIZE),
    .DATA_WIDTH (ACT_DATA_WIDTH),
    .ADDR_WIDTH (16),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .cfg_base_addr      (cfg_base_addr),
    .cfg_rows           (cfg_rows),
    .cfg_k_tiles        (cfg_k_tiles),
    .busy               (busy),
    .done               (done),
    .mem_rd_en          (mem_rd_en),
    .mem_rd_addr        (mem_rd_addr),
    .mem_rd_data        (mem_rd_data),
    .act_valid          (act_valid),
    .act_data           (act_data),
    .act_ready          (act_ready),
    .perf_stall_cycles  (perf_stall_cycles),
    .perf_bubble_cycles (perf_bubble_cycles)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Reference SRAM contents.
  logic        simple_pat = 1'b1;
  logic [15:0] pat_base = 16'h0010;

  function automatic logic [31:0] word(input logic [15:0] a);
    logic [7:0] v;
    if (simple_pat) begin
      v = 8'(a - pat_base + 16'd1);
      return {4{v}};
    end
    return (32'(a) * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Scoreboard queues and per-stream statistics.
  logic [15:0] exp_addr[$];
  logic [31:0] exp_data[$];
  int          hs_rel[$];
  int          t0 = 0;
  int          done_cnt, done_rel, first_rd_rel, rd_total, pop_total, max_out;
  int          stall_exp, bubble_exp;
  logic        busy_at_done, busy_seen, hold_prev;
  logic [31:0] prev_data;

  task automatic clear_stats();
    done_cnt = 0; done_rel = -1; first_rd_rel = -1; rd_total = 0; pop_total = 0;
    max_out = 0; stall_exp = 0; bubble_exp = 0; busy_at_done = 1'b0;
    busy_seen = 1'b0; hold_prev = 1'b0; prev_data = '0;
    hs_rel.delete();
  endtask

  // SRAM model: one-cycle read latency, data holds between reads.
  initial begin
    logic        req;
    logic [15:0] a;
    forever begin
      @(negedge clk);
      req = mem_rd_en;
      a   = mem_rd_addr;
      @(posedge clk);
      #1;
      if (req) mem_rd_data = word(a);
    end
  end

  // Array-side ready driver.
  int ready_mode = 0;
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       act_ready = 1'b1;
        1:       begin act_ready = (ph == 0); ph = (ph + 1) % 3; end
        default: act_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compares reads and accepted vectors against the scoreboard.
  always @(negedge clk) begin
    int out_now;
    out_now = rd_total - pop_total + (mem_rd_en ? 1 : 0);
    if (out_now > max_out) max_out = out_now;
    if (mem_rd_en) begin
      if (first_rd_rel < 0) first_rd_rel = cyc - t0;
      rd_total++;
      if (exp_addr.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_addr: unexpected read of %0h, none required", mem_rd_addr);
      end else begin
        check("rd_addr", 64'(mem_rd_addr), 64'(exp_addr.pop_front()));
      end
    end
    if (hold_prev) begin
      check("hold_valid", 64'(act_valid), 64'd1);
      check("hold_data", 64'(act_data), 64'(prev_data));
    end
    if (act_valid && act_ready) begin
      pop_total++;
      hs_rel.push_back(cyc - t0);
      if (exp_data.size() == 0) begin
        checks++; errors++;
        $display("FAIL act_data: unexpected vector %0h, none required", act_data);
      end else begin
        check("act_data", 64'(act_data), 64'(exp_data.pop_front()));
      end
    end
    if (act_valid && !act_ready) stall_exp++;
    if (busy && !act_valid) bubble_exp++;
    if (busy) busy_seen = 1'b1;
    if (done) begin
      done_cnt++;
      done_rel = cyc - t0;
      busy_at_done = busy;
    end
    hold_prev = act_valid && !act_ready;
    prev_data = act_data;
  end

  task automatic start_stream(input logic [15:0] base, input logic [15:0] rows,
                              input logic [15:0] k);
    int unsigned n;
    @(posedge clk);
    #1;
    clear_stats();
    exp_addr.delete();
    exp_data.delete();
    t0 = cyc;
    n = int'(rows) * int'(k);
    for (int unsigned i = 0; i < n; i++) begin
      exp_addr.push_back(16'(base + 16'(i)));
      exp_data.push_back(word(16'(base + 16'(i))));
    end
    cfg_base_addr = base;
    cfg_rows      = rows;
    cfg_k_tiles   = k;
    start         = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) break;
    end
    if (i == limit) begin
      checks++; errors++;
      $display("FAIL wait_done: no done within %0d cycles", limit);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic end_checks(input string tag, input int unsigned n);
    check({tag, "_data_left"}, 64'(exp_data.size()), 64'd0);
    check({tag, "_addr_left"}, 64'(exp_addr.size()), 64'd0);
    check({tag, "_done_count"}, 64'(done_cnt), 64'd1);
    check({tag, "_busy_at_done"}, 64'(busy_at_done), 64'd0);
    check({tag, "_busy_seen"}, 64'(busy_seen), 64'(n != 0));
    check({tag, "_outstanding_ok"}, 64'(max_out <= DEPTH), 64'd1);
    check({tag, "_pops"}, 64'(pop_total), 64'(n));
`ifdef ACT_STREAM_FEEDER_PERF_EN
    check({tag, "_perf_stall"}, 64'(perf_stall_cycles), 64'(stall_exp));
    check({tag, "_perf_bubble"}, 64'(perf_bubble_cycles), 64'(bubble_exp));
`else
    check({tag, "_perf_stall"}, 64'(perf_stall_cycles), 64'd0);
    check({tag, "_perf_bubble"}, 64'(perf_bubble_cycles), 64'd0);
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_rd_en"}, 64'(mem_rd_en), 64'd0);
    check({tag, "_rd_addr"}, 64'(mem_rd_addr), 64'd0);
    check({tag, "_act_valid"}, 64'(act_valid), 64'd0);
    check({tag, "_act_data"}, 64'(act_data), 64'd0);
    check({tag, "_perf_stall"}, 64'(perf_stall_cycles), 64'd0);
    check({tag, "_perf_bubble"}, 64'(perf_bubble_cycles), 64'd0);
  endtask

  initial begin
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    // Single stream, ready held high: exact timing.
    simple_pat = 1'b1; pat_base = 16'h0010; ready_mode = 0;
    start_stream(16'h0010, 16'd2, 16'd2);
    wait_done(100);
    end_checks("single", 4);
    check("single_first_rd_cycle", 64'(first_rd_rel), 64'd1);
    check("single_done_cycle", 64'(done_rel), 64'd6);
    check("single_hs_count", 64'(hs_rel.size()), 64'd4);
    for (int i = 0; i < hs_rel.size(); i++) check("single_hs_cycle", 64'(hs_rel[i]), 64'(i + 2));

    // Backpressure with ready pattern 1,0,0.
    ready_mode = 1;
    start_stream(16'h0010, 16'd2, 16'd2);
    wait_done(200);
    end_checks("backpressure", 4);
    ready_mode = 0;

    // Empty stream.
    start_stream(16'h0020, 16'd0, 16'd5);
    wait_done(20);
    end_checks("empty", 0);
    check("empty_done_cycle", 64'(done_rel), 64'd1);
    check("empty_reads", 64'(rd_total), 64'd0);

    // Address wrap.
    simple_pat = 1'b0; ready_mode = 2;
    start_stream(16'hFFFE, 16'd1, 16'd4);
    wait_done(200);
    end_checks("wrap", 4);

    // Start while busy is ignored.
    ready_mode = 0; simple_pat = 1'b1; pat_base = 16'h0010;
    start_stream(16'h0010, 16'd2, 16'd2);
    cfg_base_addr = 16'h0500; cfg_rows = 16'd7; cfg_k_tiles = 16'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(100);
    repeat (5) @(posedge clk);
    #1;
    end_checks("start_busy", 4);

    // Reset mid-stream while a read is in flight at vector 3 of 8.
    pat_base = 16'h0040;
    start_stream(16'h0040, 16'd2, 16'd4);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_addr.delete();
    exp_data.delete();
    clear_stats();
    @(negedge clk);
    check_reset_outputs("midreset");
    simple_pat = 1'b0;
    start_stream(16'h0300, 16'd1, 16'd3);
    wait_done(100);
    end_checks("after_reset", 3);

    // Randomized streams.
    for (int s = 0; s < 8; s++) begin
      logic [15:0] b, r, k;
      b = 16'($urandom);
      r = 16'($urandom_range(0, 5));
      k = 16'($urandom_range(0, 5));
      ready_mode = s % 3;
      start_stream(b, r, k);
      wait_done(400);
      end_checks("random", int'(r) * int'(k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, %0d errors so far", errors);
    $fatal(1);
  end

endmodule
